// File: rtl/event_serializer.sv
// ----------------------------------------------------------------------------
// event_serializer
//
// Consumer end of the event tuple stream (x, y, t, p). Tuples arrive over a
// valid/ready handshake and are buffered in a small FIFO. Each buffered tuple
// is sent out MSB-first as a framed byte stream with byte-level valid/ready:
//   SYNC_BYTE, x[15:8], x[7:0], y[15:8], y[7:0], t[15:8], t[7:0], {7'b0, p}
// With DROP_LOW=1, tuples with p=0 are accepted, discarded and counted.
//
// Optional feature (compile-time macro EVT_SERIALIZER_CHECKSUM_EN):
//   a 9th byte is appended, the XOR of bytes 1..7 (sync byte excluded).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   evt_valid/ready   tuple handshake; evt_ready = FIFO not full
//   evt_x/y/t/p       tuple fields
//   byte_data/valid   serialized byte stream towards downstream
//   byte_ready        downstream takes the byte this cycle
//   fifo_level        tuples waiting in the FIFO (frame in shifter excluded)
//   drop_cnt          saturating count of discarded tuples
//   busy              frame in flight or FIFO non-empty
// ----------------------------------------------------------------------------
module event_serializer #(
    parameter int         DEPTH     = 4,
    parameter bit         DROP_LOW  = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     evt_valid,
    output logic                     evt_ready,
    input  logic [15:0]              evt_x,
    input  logic [15:0]              evt_y,
    input  logic [15:0]              evt_t,
    input  logic                     evt_p,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int EW    = 49;  // {x, y, t, p}

`ifdef EVT_SERIALIZER_CHECKSUM_EN
    localparam int FRAME_BYTES = 9;
`else
    localparam int FRAME_BYTES = 8;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem_q [DEPTH];
    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level;
    state_t           state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [EW-1:0]    head;
    logic             full, empty, accept, drop, push, pop;
    logic             byte_fire, last_byte;
`ifdef EVT_SERIALIZER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit, so their difference is the level
    // and full/empty need no separate flag.
    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    assign accept    = evt_valid && !full;
    assign drop      = accept && DROP_LOW && !evt_p;
    assign push      = accept && !drop;

    assign byte_fire = (state_q == SEND) && byte_ready;
    assign last_byte = (byte_idx_q == LAST_IDX);
    // Pop either from IDLE or on the last byte of a frame, so back-to-back
    // frames leave no idle cycle between them.
    assign pop       = !empty && ((state_q == IDLE) || (byte_fire && last_byte));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        wr_ptr_d   = wr_ptr_q + LVL_W'(push);
        rd_ptr_d   = rd_ptr_q + LVL_W'(pop);
        drop_cnt_d = drop_cnt_q;
`ifdef EVT_SERIALIZER_CHECKSUM_EN
        chk_d      = chk_q;
`endif

        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end

        if (pop) begin
            state_d    = SEND;
            shift_d    = {SYNC_BYTE, head[48:1], 7'b0, head[0]};
            byte_idx_d = '0;
`ifdef EVT_SERIALIZER_CHECKSUM_EN
            chk_d      = '0;
`endif
        end else if (byte_fire) begin
            // Zeros shift in behind the frame, so byte_data reads 0 once idle.
            shift_d    = {shift_q[55:0], 8'h00};
            byte_idx_d = byte_idx_q + 1'b1;
            if (last_byte) begin
                state_d    = IDLE;
                byte_idx_d = '0;
            end
`ifdef EVT_SERIALIZER_CHECKSUM_EN
            // Checksum accumulates bytes 1..7 as they leave the shifter.
            if ((byte_idx_q != 4'd0) && (byte_idx_q != LAST_IDX)) begin
                chk_d = chk_q ^ shift_q[63:56];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef EVT_SERIALIZER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // NOTE: FIFO storage has no reset; the pointers alone define which entries
    // are valid, and a resettable array would cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {evt_x, evt_y, evt_t, evt_p};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign evt_ready  = !full;
    assign byte_valid = (state_q == SEND);
`ifdef EVT_SERIALIZER_CHECKSUM_EN
    assign byte_data  = (byte_idx_q == LAST_IDX) ? chk_q : shift_q[63:56];
`else
    assign byte_data  = shift_q[63:56];
`endif
    assign fifo_level = level;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_event_serializer.sv
// ----------------------------------------------------------------------------
// tb_event_serializer
//
// Directed bench for event_serializer (DEPTH=4, DROP_LOW=1, SYNC=A5, CNT_W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_event_serializer;

`ifdef EVT_SERIALIZER_CHECKSUM_EN
    localparam int FRAME_N = 9;
`else
    localparam int FRAME_N = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_x, evt_y, evt_t;
    logic        evt_p;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Hand-computed frame for x=1234 y=0056 t=BEEF p=1; last entry is the
    // checksum 12^34^00^56^BE^EF^01 = 20.
    logic [7:0] s1_exp [9] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h56,
                               8'hBE, 8'hEF, 8'h01, 8'h20};

    event_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_x      (evt_x),
        .evt_y      (evt_y),
        .evt_t      (evt_t),
        .evt_p      (evt_p),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [15:0] x, input logic [15:0] y,
                                              input logic [15:0] t, input logic p, input int i);
        logic [7:0] f [9];
        f[0] = 8'hA5;
        f[1] = x[15:8];
        f[2] = x[7:0];
        f[3] = y[15:8];
        f[4] = y[7:0];
        f[5] = t[15:8];
        f[6] = t[7:0];
        f[7] = {7'b0, p};
        f[8] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6] ^ f[7];
        return f[i];
    endfunction

    // Called at a falling edge with byte_ready=1: waits (bounded) for a valid
    // byte, returns it, and steps past the edge that consumes it.
    task automatic get_byte(output logic [7:0] b, output int waits);
        waits = 0;
        while (!byte_valid && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        check("byte_valid_seen", byte_valid, 1'b1);
        b = byte_data;
        @(negedge clk);
    endtask

    // Receives one full frame and requires every byte to be present with no gap.
    task automatic recv_frame(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] t, input logic p);
        logic [7:0] b;
        int         w;
        for (int i = 0; i < FRAME_N; i++) begin
            get_byte(b, w);
            check($sformatf("%s_byte%0d", tag, i), b, frame_byte(x, y, t, p, i));
            check($sformatf("%s_gap%0d", tag, i), w, 0);
        end
    endtask

    task automatic drive_tuple(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] t, input logic p);
        evt_valid = 1'b1;
        evt_x     = x;
        evt_y     = y;
        evt_t     = t;
        evt_p     = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         w;
        int         got;
        int         stalled;
        logic [7:0] held;
        int         vcount;
        int         pat [12] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1};

        rst_n      = 1'b0;
        evt_valid  = 1'b0;
        evt_x      = '0;
        evt_y      = '0;
        evt_t      = '0;
        evt_p      = 1'b0;
        byte_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_data",  byte_data,  8'h00);
        check("rst_fifo_level", fifo_level, 3'd0);
        check("rst_drop_cnt",   drop_cnt,   8'h00);
        check("rst_busy",       busy,       1'b0);
        check("rst_evt_ready",  evt_ready,  1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- 1: single tuple, latency and byte order ----------------
        drive_tuple(16'h1234, 16'h0056, 16'hBEEF, 1'b1);
        @(negedge clk);                       // edge N accepted the tuple
        evt_valid = 1'b0;
        check("s1_valid_at_N",  byte_valid, 1'b0);
        check("s1_level_at_N",  fifo_level, 3'd1);
        check("s1_busy_at_N",   busy,       1'b1);
        @(negedge clk);                       // edge N+1 popped it
        check("s1_valid_N1",    byte_valid, 1'b1);
        check("s1_level_N1",    fifo_level, 3'd0);
        for (int i = 0; i < FRAME_N; i++) begin
            get_byte(b, w);
            check($sformatf("s1_byte%0d", i), b, s1_exp[i]);
            check($sformatf("s1_gap%0d", i), w, 0);
        end
        check("s1_valid_after", byte_valid, 1'b0);
        check("s1_busy_after",  busy,       1'b0);

        // ---------------- 2: dropped tuples, saturation ----------------
        drive_tuple(16'h1111, 16'h2222, 16'h3333, 1'b0);
        @(negedge clk);
        evt_valid = 1'b0;
        @(negedge clk);
        check("s2_drop_one",    drop_cnt,   8'd1);
        check("s2_no_valid",    byte_valid, 1'b0);
        check("s2_level",       fifo_level, 3'd0);
        check("s2_busy",        busy,       1'b0);
        drive_tuple(16'h1111, 16'h2222, 16'h3333, 1'b0);
        repeat (299) @(negedge clk);
        evt_valid = 1'b0;
        @(negedge clk);
        check("s2_drop_sat",    drop_cnt,   8'hFF);
        check("s2_ready_kept",  evt_ready,  1'b1);
        check("s2_no_valid_sat", byte_valid, 1'b0);

        // ---------------- 3: back-pressure, full FIFO, ordering ----------------
        byte_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s3_ready_before%0d", k), evt_ready, 1'b1);
            drive_tuple(16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k), 1'b1);
            @(negedge clk);
        end
        drive_tuple(16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b1);   // 6th tuple must not enter
        check("s3_level_full",  fifo_level, 3'd4);
        check("s3_ready_full",  evt_ready,  1'b0);
        check("s3_hold_sync",   byte_data,  8'hA5);
        repeat (2) @(negedge clk);
        check("s3_level_held",  fifo_level, 3'd4);
        check("s3_ready_held",  evt_ready,  1'b0);
        evt_valid  = 1'b0;
        byte_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            recv_frame($sformatf("s3_f%0d", k),
                       16'h1000 + 16'(k), 16'h2000 + 16'(k), 16'h3000 + 16'(k), 1'b1);
        end
        check("s3_valid_after", byte_valid, 1'b0);
        check("s3_level_after", fifo_level, 3'd0);

        // ---------------- 4: byte_ready toggling mid-frame ----------------
        byte_ready = 1'b0;
        drive_tuple(16'h1234, 16'h0056, 16'hBEEF, 1'b1);
        @(negedge clk);
        evt_valid = 1'b0;
        @(negedge clk);
        got     = 0;
        stalled = 0;
        held    = '0;
        for (int c = 0; c < 40 && got < FRAME_N; c++) begin
            if (stalled != 0) begin
                check($sformatf("s4_stable_c%0d", c), byte_data, held);
                check($sformatf("s4_valid_held_c%0d", c), byte_valid, 1'b1);
            end
            byte_ready = (c < 12) ? pat[c][0] : 1'b1;
            if (byte_valid && byte_ready) begin
                check($sformatf("s4_byte%0d", got), byte_data, s1_exp[got]);
                got++;
            end
            stalled = (byte_valid && !byte_ready) ? 1 : 0;
            held    = byte_data;
            @(negedge clk);
        end
        check("s4_byte_count",  got,        FRAME_N);
        byte_ready = 1'b1;
        check("s4_valid_after", byte_valid, 1'b0);

        // ---------------- 5: reset mid-frame ----------------
        byte_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_tuple(16'h4000 + 16'(k), 16'h5000, 16'h6000, 1'b1);
            @(negedge clk);
        end
        evt_valid = 1'b0;
        check("s5_level_two",   fifo_level, 3'd2);
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            get_byte(b, w);
            check($sformatf("s5_byte%0d", i), b, frame_byte(16'h4000, 16'h5000, 16'h6000, 1'b1, i));
        end
        byte_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("s5_rst_valid",   byte_valid, 1'b0);
        check("s5_rst_level",   fifo_level, 3'd0);
        check("s5_rst_data",    byte_data,  8'h00);
        check("s5_rst_drop",    drop_cnt,   8'h00);
        check("s5_rst_busy",    busy,       1'b0);
        check("s5_rst_ready",   evt_ready,  1'b1);
        @(negedge clk);
        rst_n      = 1'b1;
        byte_ready = 1'b1;
        vcount     = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (byte_valid) vcount++;
        end
        check("s5_no_residual", vcount,     0);
        check("s5_level_final", fifo_level, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
